// File: rtl/cluster_readout_encoder.sv
// Cluster readout encoder: turns a 256-strip hit map into a header word,
// one cluster word per lowest-set-bit group of four strips, and a trailer.
module cluster_readout_encoder #(
    parameter int MAX_CLUST = 64
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         START,
    input  logic         NO_0_1,
    input  logic [271:0] DIN,
    input  logic         OUT_READY,
    output logic         BUSY,
    output logic         OUT_VALID,
    output logic [1:0]   OUT_TYPE,
    output logic [15:0]  OUT_DATA,
    output logic         DROPPED
);

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        SCAN,
        TRAILER
    } state_t;

    localparam logic [6:0] MAX_C = 7'(MAX_CLUST);

    state_t       state;
    logic [255:0] hit;
    logic [15:0]  tag;
    logic [6:0]   count;
    logic         ovf;
    logic         empty;
    logic [7:0]   cur_a;

    logic         xfer;
    logic [255:0] src;
    logic [6:0]   src_cnt;
    logic         src_any;
    logic         room;
    logic         ovf_n;
    logic [7:0]   a;
    logic [258:0] ext;
    logic [2:0]   next3;

    assign xfer = OUT_VALID && OUT_READY;

    // The next word is chosen from the hit map as it will be after the
    // current transfer, so consecutive words follow with no idle cycle.
    always_comb begin
        src     = hit;
        src_cnt = count;
        if (state == SCAN) begin
            src     = hit & ~(256'hF << cur_a);
            src_cnt = count + 7'd1;
        end
        src_any = |src;
        room    = src_cnt < MAX_C;
        ovf_n   = ovf | (src_any & ~room);
        a       = 8'd0;
        for (int i = 255; i >= 0; i--) begin
            if (src[i]) begin
                a = 8'(i);
            end
        end
        ext   = {3'b000, src};
        next3 = ext[9'(a) + 9'd1 +: 3];
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            hit       <= '0;
            tag       <= '0;
            count     <= '0;
            ovf       <= 1'b0;
            empty     <= 1'b0;
            cur_a     <= '0;
            BUSY      <= 1'b0;
            OUT_VALID <= 1'b0;
            OUT_TYPE  <= 2'b00;
            OUT_DATA  <= '0;
            DROPPED   <= 1'b0;
        end else begin
            DROPPED <= BUSY && (START || NO_0_1);
            case (state)
                IDLE: begin
                    if (START || NO_0_1) begin
                        hit       <= START ? DIN[255:0] : '0;
                        empty     <= ~START;
                        tag       <= DIN[271:256];
                        count     <= '0;
                        ovf       <= 1'b0;
                        state     <= HEADER;
                        BUSY      <= 1'b1;
                        OUT_VALID <= 1'b1;
                        OUT_TYPE  <= 2'b01;
                        OUT_DATA  <= DIN[271:256];
                    end
                end
                HEADER, SCAN: begin
                    if (xfer) begin
                        hit   <= src;
                        count <= src_cnt;
                        if (src_any && room) begin
                            state    <= SCAN;
                            cur_a    <= a;
                            OUT_TYPE <= 2'b10;
                            OUT_DATA <= {a, next3, 5'b00000};
                        end else begin
                            // Hits left over at the cluster limit are dropped.
                            state    <= TRAILER;
                            ovf      <= ovf_n;
                            OUT_TYPE <= 2'b11;
                            OUT_DATA <= {ovf_n, empty, 7'd0, src_cnt};
                        end
                    end
                end
                TRAILER: begin
                    if (xfer) begin
                        state     <= IDLE;
                        BUSY      <= 1'b0;
                        OUT_VALID <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cluster_readout_encoder.sv
// Bench for cluster_readout_encoder: directed table, corner sequences and
// random events compared with a word-list model of the readout rules.
module tb_cluster_readout_encoder;

    localparam int MAXC = 8;

    logic         CLK = 1'b0;
    logic         RST;
    logic         START;
    logic         NO_0_1;
    logic [271:0] DIN;
    logic         OUT_READY;
    logic         BUSY;
    logic         OUT_VALID;
    logic [1:0]   OUT_TYPE;
    logic [15:0]  OUT_DATA;
    logic         DROPPED;

    cluster_readout_encoder #(.MAX_CLUST(MAXC)) dut (
        .CLK(CLK),
        .RST(RST),
        .START(START),
        .NO_0_1(NO_0_1),
        .DIN(DIN),
        .OUT_READY(OUT_READY),
        .BUSY(BUSY),
        .OUT_VALID(OUT_VALID),
        .OUT_TYPE(OUT_TYPE),
        .OUT_DATA(OUT_DATA),
        .DROPPED(DROPPED)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [255:0] hits;
        logic [15:0]  tag;
        bit           st;
        bit           nz;
        int           nclu;
        logic [15:0]  clu0;
        logic [15:0]  trailer;
    } vec_t;

    vec_t        tbl[7];
    logic [17:0] got[$];
    logic [17:0] exp_q[$];
    int          busy_cyc;
    int          total = 0;
    int          bad = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Reference: peel the lowest hit, report its next three strips, clear
    // four strips, repeat until empty or the cluster limit is reached.
    task automatic model(input logic [255:0] h, input logic [15:0] tg,
                         input bit st, input bit nz);
        logic [255:0] m;
        int cnt;
        int a;
        int d;
        bit emp;
        exp_q.delete();
        emp = !st && nz;
        m = st ? h : '0;
        exp_q.push_back({2'b01, tg});
        cnt = 0;
        while (m != 0 && cnt < MAXC) begin
            a = 0;
            while (!m[a]) a++;
            d = a * 256;
            for (int k = 1; k <= 3; k++)
                if (a + k <= 255 && m[a + k]) d += 1 << (4 + k);
            exp_q.push_back({2'b10, 16'(d)});
            for (int k = 0; k <= 3; k++)
                if (a + k <= 255) m[a + k] = 1'b0;
            cnt++;
        end
        d = cnt + (emp ? 16384 : 0) + ((m != 0) ? 32768 : 0);
        exp_q.push_back({2'b11, 16'(d)});
    endtask

    task automatic launch(input logic [255:0] h, input logic [15:0] tg,
                          input bit st, input bit nz);
        DIN = {tg, h};
        START = st;
        NO_0_1 = nz;
        step();
        START = 1'b0;
        NO_0_1 = 1'b0;
        DIN = ~DIN;
        chk("lat_busy", 32'(BUSY), 1);
        chk("lat_valid", 32'(OUT_VALID), 1);
        chk("hdr_type", 32'(OUT_TYPE), 1);
        chk("hdr_tag", 32'(OUT_DATA), 32'(tg));
    endtask

    task automatic collect(input bit rnd);
        bit done;
        bit stall;
        int budget;
        logic [17:0] pw;
        got.delete();
        busy_cyc = 0;
        done = 0;
        stall = 0;
        budget = 0;
        pw = '0;
        while (!done && budget < 3000) begin
            OUT_READY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (BUSY) busy_cyc++;
            if (stall)
                chk("stall_hold", {OUT_VALID, OUT_TYPE, OUT_DATA},
                    {1'b1, pw});
            if (OUT_VALID && OUT_READY) begin
                got.push_back({OUT_TYPE, OUT_DATA});
                if (OUT_TYPE == 2'b11) done = 1;
                stall = 0;
            end else if (OUT_VALID) begin
                stall = 1;
                pw = {OUT_TYPE, OUT_DATA};
            end else begin
                stall = 0;
            end
            step();
            budget++;
        end
        OUT_READY = 1'b1;
        chk("trailer_seen", 32'(done), 1);
        chk("end_busy", 32'(BUSY), 0);
        chk("end_valid", 32'(OUT_VALID), 0);
    endtask

    task automatic cmp_seq(input string nm);
        chk({nm, "_nwords"}, got.size(), exp_q.size());
        for (int i = 0; i < got.size() && i < exp_q.size(); i++)
            chk($sformatf("%s_word%0d", nm, i), 32'(got[i]), 32'(exp_q[i]));
    endtask

    function automatic logic [255:0] rnd_hits(input int mode);
        logic [255:0] h;
        h = '0;
        case (mode)
            0: repeat ($urandom_range(1, 6)) h[$urandom_range(0, 255)] = 1'b1;
            1: for (int i = 0; i < 8; i++)
                   h[i*32 +: 32] = $urandom & $urandom & $urandom & $urandom;
            default: begin
                h[255 -: 8] = 8'($urandom);
                h[$urandom_range(0, 7)] = 1'b1;
            end
        endcase
        return h;
    endfunction

    initial begin
        logic [255:0] h;
        logic [255:0] every4;
        int nclu;
        int sel;

        every4 = '0;
        for (int i = 0; i < 256; i += 4) every4[i] = 1'b1;
        h = '0;
        h[3] = 1'b1; h[4] = 1'b1; h[6] = 1'b1; h[100] = 1'b1;
        tbl[0] = '{h, 16'hBEEF, 1, 0, 2, 16'h03A0, 16'h0002};
        tbl[1] = '{'1, 16'h0012, 0, 1, 0, 16'h0000, 16'h4000};
        tbl[2] = '{every4, 16'h0444, 1, 0, 8, 16'h0000, 16'h8008};
        h = '0;
        h[254] = 1'b1; h[255] = 1'b1;
        tbl[3] = '{h, 16'h0254, 1, 0, 1, 16'hFE20, 16'h0001};
        h = '0;
        h[0] = 1'b1; h[255] = 1'b1;
        tbl[4] = '{h, 16'h0F0F, 1, 0, 2, 16'h0000, 16'h0002};
        tbl[5] = '{'0, 16'hA5A5, 1, 0, 0, 16'h0000, 16'h0000};
        h = '0;
        h[10] = 1'b1;
        tbl[6] = '{h, 16'h1234, 1, 1, 1, 16'h0A00, 16'h0001};

        RST = 1'b1;
        START = 1'b0;
        NO_0_1 = 1'b0;
        DIN = '0;
        OUT_READY = 1'b1;
        step();
        step();
        chk("rst_busy", 32'(BUSY), 0);
        chk("rst_valid", 32'(OUT_VALID), 0);
        chk("rst_type", 32'(OUT_TYPE), 0);
        chk("rst_data", 32'(OUT_DATA), 0);
        chk("rst_drop", 32'(DROPPED), 0);
        RST = 1'b0;
        step();

        foreach (tbl[v]) begin
            model(tbl[v].hits, tbl[v].tag, tbl[v].st, tbl[v].nz);
            launch(tbl[v].hits, tbl[v].tag, tbl[v].st, tbl[v].nz);
            collect(0);
            cmp_seq($sformatf("tbl%0d", v));
            nclu = 0;
            foreach (got[i]) if (got[i][17:16] == 2'b10) nclu++;
            chk($sformatf("tbl%0d_nclu", v), nclu, tbl[v].nclu);
            if (tbl[v].nclu > 0 && got.size() > 1)
                chk($sformatf("tbl%0d_clu0", v), 32'(got[1]),
                    {16'd0, 2'b10, tbl[v].clu0});
            if (got.size() > 0)
                chk($sformatf("tbl%0d_trl", v), 32'(got[got.size()-1]),
                    {16'd0, 2'b11, tbl[v].trailer});
            chk($sformatf("tbl%0d_busy", v), busy_cyc, got.size());
        end

        // Requests while busy are dropped and leave the event intact.
        h = '0;
        h[20] = 1'b1; h[22] = 1'b1; h[50] = 1'b1;
        model(h, 16'h7777, 1, 0);
        OUT_READY = 1'b0;
        launch(h, 16'h7777, 1, 0);
        step();
        START = 1'b1;
        DIN = {16'h1111, 256'h1};
        step();
        START = 1'b0;
        chk("drop_start", 32'(DROPPED), 1);
        chk("drop_hold", {14'd0, OUT_VALID, OUT_TYPE, OUT_DATA},
            {14'd0, 1'b1, 2'b01, 16'h7777});
        step();
        chk("drop_clear", 32'(DROPPED), 0);
        NO_0_1 = 1'b1;
        step();
        NO_0_1 = 1'b0;
        chk("drop_no01", 32'(DROPPED), 1);
        repeat (4) step();
        chk("stall_busy", 32'(BUSY), 1);
        chk("stall_word", {OUT_TYPE, OUT_DATA}, {2'b01, 16'h7777});
        collect(0);
        cmp_seq("drop");

        // Reset during the scan aborts; a START alongside it is ignored.
        launch(every4, 16'h5555, 1, 0);
        step();
        step();
        RST = 1'b1;
        START = 1'b1;
        DIN = {16'h9999, every4};
        step();
        RST = 1'b0;
        START = 1'b0;
        chk("mid_rst_valid", 32'(OUT_VALID), 0);
        chk("mid_rst_busy", 32'(BUSY), 0);
        chk("mid_rst_data", 32'(OUT_DATA), 0);
        step();
        chk("rst_start_ign", 32'(BUSY), 0);
        h = '0;
        h[77] = 1'b1;
        model(h, 16'h00AB, 1, 0);
        launch(h, 16'h00AB, 1, 0);
        collect(0);
        cmp_seq("post_rst");

        // Random events, half with a randomly stalling consumer.
        for (int e = 0; e < 40; e++) begin
            h = rnd_hits($urandom_range(0, 2));
            sel = $urandom_range(0, 9);
            model(h, 16'($urandom), sel != 0, sel < 3);
            launch(h, exp_q[0][15:0], sel != 0, sel < 3);
            collect(1'($urandom_range(0, 1)));
            cmp_seq($sformatf("rnd%0d", e));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cluster_readout_encoder.md
CLUSTER_READOUT_ENCODER -- requirements
Module: cluster_readout_encoder

Interface
REQ-001 SHALL have parameter MAX_CLUST, default 64: the maximum number of cluster words per event, legal range 1..64.
REQ-002 SHALL have port CLK, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-003 SHALL have port RST, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port START, input, 1 bit: one-cycle pulse; a hit event is ready on DIN.
REQ-005 SHALL have port NO_0_1, input, 1 bit: one-cycle pulse; the event has no 0->1 transition and is read out as an empty event.
REQ-006 SHALL have port DIN, input, 272 bits: [255:0] strip hit map, [271:256] 16-bit event tag.
REQ-007 SHALL have port OUT_READY, input, 1 bit: the downstream serializer accepts a word.
REQ-008 SHALL have port BUSY, output, 1 bit: an event is in progress; this port drives the upstream busy input.
REQ-009 SHALL have port OUT_VALID, output, 1 bit: OUT_DATA and OUT_TYPE are valid.
REQ-010 SHALL have port OUT_TYPE, output, 2 bits: word type; 01 header, 10 cluster, 11 trailer.
REQ-011 SHALL have port OUT_DATA, output, 16 bits: word payload.
REQ-012 SHALL have port DROPPED, output, 1 bit: one-cycle pulse when START or NO_0_1 arrives while BUSY=1.

Function
REQ-013 SHALL implement states IDLE, HEADER, SCAN and TRAILER; BUSY SHALL equal (state != IDLE) and SHALL be registered.
REQ-014 In IDLE, when START=1, the block SHALL latch DIN into an internal hit register and a tag register, clear the cluster count and overflow flag, and enter HEADER on the next edge.
REQ-015 In IDLE, when NO_0_1=1 and START=0, the block SHALL latch the tag only, force the hit register to 0, set the empty flag, and enter HEADER.
REQ-016 When START and NO_0_1 are both 1 in the same cycle, START SHALL take priority.
REQ-017 Latency: START at cycle n SHALL give BUSY=1 and OUT_VALID=1 with the header word at cycle n+1.
REQ-018 A word transfers on a cycle with OUT_VALID&&OUT_READY; OUT_VALID, OUT_TYPE and OUT_DATA SHALL stay stable until the transfer, and OUT_VALID SHALL never drop before it.
REQ-019 Header word SHALL be: OUT_TYPE=01, OUT_DATA=tag; after transfer the state SHALL go to SCAN.
REQ-020 In SCAN with hits!=0 and count<MAX_CLUST, the block SHALL present a cluster word built from the lowest set bit a.
- OUT_TYPE=10.
- OUT_DATA[15:8]=a.
- OUT_DATA[7:5]={hit[a+3],hit[a+2],hit[a+1]}.
- OUT_DATA[4:0]=0.
REQ-021 Bits of the cluster word with index >255 SHALL read as 0, so a=254 gives OUT_DATA[7:5]=3'b001.
REQ-022 On transfer of a cluster word, hit bits a..a+3 (clipped at 255) SHALL be cleared and count SHALL increment.
REQ-023 In SCAN with hits==0, the state SHALL go to TRAILER without emitting a word.
REQ-024 In SCAN with count==MAX_CLUST and hits!=0, the block SHALL set the overflow flag and go to TRAILER; the remaining hits are discarded.
REQ-025 Each cluster word SHALL be presented no later than one cycle after the previous transfer; the scan SHALL be a single-cycle priority encode over 256 bits.
REQ-026 Trailer word SHALL be:
- OUT_TYPE=11.
- OUT_DATA[15]=overflow.
- OUT_DATA[14]=empty flag.
- OUT_DATA[13:7]=0.
- OUT_DATA[6:0]=count.
REQ-027 After the trailer transfers, the state SHALL return to IDLE with BUSY=0 on the next cycle; a new START SHALL be accepted in that IDLE cycle.
REQ-028 START or NO_0_1 while BUSY=1 SHALL be ignored, SHALL pulse DROPPED for 1 cycle, and SHALL not disturb the event in progress.
REQ-029 When OUT_READY=0 indefinitely, the block SHALL hold its word with no loss and no counter change.
REQ-030 The count SHALL be 7 bits and SHALL never wrap, because it is bounded by MAX_CLUST<=64.

Reset
REQ-031 With RST=1 at a clock edge, on the next cycle:
- state=IDLE.
- BUSY=0, OUT_VALID=0, DROPPED=0.
- OUT_TYPE=00, OUT_DATA=0.
- hit register, tag, count, overflow flag and empty flag all 0.
REQ-032 Reset mid-event SHALL abort the event without a trailer; START in the same cycle as RST=1 SHALL be ignored.

Verification
REQ-033 Hits at bits 3,4,6,100 with tag 0xBEEF and OUT_READY=1 -> words:
- header BEEF.
- cluster a=3, next3=101.
- cluster a=100, next3=000.
- trailer count=2.
- BUSY high for 4 cycles.
REQ-034 NO_0_1 with tag 0x0012 -> header 0012, then trailer 0x4000; no cluster words.
REQ-035 Every 4th bit set (64 clusters) with MAX_CLUST=8 -> 8 clusters at a=0,4,...,28, then trailer 0x8008.
REQ-036 Hits at bits 254,255 -> a single cluster word with a=254, next3=001, then trailer count=1.
REQ-037 OUT_READY toggled randomly -> the word sequence is identical to the OUT_READY=1 run and outputs are stable while stalled.
REQ-038 START while BUSY -> DROPPED pulses 1 cycle and the current event completes unchanged; RST mid-SCAN -> OUT_VALID=0 and BUSY=0 on the next cycle.
